instruction_memory_ld_fp: RTL and testbench
===========================================

# instruction_memory_ld_fp

Byte-addressed, parametrised instruction memory with a serial program-load port and a registered, fault-checked fetch port. It replaces the fixed 256-byte combinational instruction store in the FP CPU fetch stage. A program is streamed in one byte per cycle before execution, then fetched as little-endian instructions of INSTR_BYTES bytes with one-cycle latency.

## Interface
- ADDR_W, 8, byte-address width; DEPTH = 2**ADDR_W bytes
- INSTR_BYTES, 4, bytes per fetched instruction (1..8)
- ALIGN_CHECK, 0, 1 = fetch at pc not a multiple of INSTR_BYTES faults
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- load_start  input  1  begin (or restart) program load at byte address 0
- load_valid  input  1  load_byte is valid this cycle
- load_byte  input  8  program byte
- load_last  input  1  with load_valid: this byte is the final one
- load_ready  output  1  block accepts load bytes (high only in LOAD)
- load_done  output  1  one-cycle pulse when load completes
- load_count  output  ADDR_W+1  number of bytes loaded in the current image
- fetch_req  input  1  fetch request at pc
- pc  input  ADDR_W  byte address of instruction's least-significant byte
- fetch_valid  output  1  instruction/fetch_fault valid (one cycle per request)
- fetch_fault  output  1  request invalid; instruction forced to 0
- instruction  output  8*INSTR_BYTES  {mem[pc+N-1], ..., mem[pc+1], mem[pc]}

## Operation
- FSM states IDLE, LOAD, RUN. Reset: IDLE, wr_ptr=0, load_count=0, load_ready=0, load_done=0, fetch_valid=0, fetch_fault=0, instruction=0. Byte array is not reset.
- IDLE/RUN --load_start--> LOAD: wr_ptr=0, load_count=0.
- LOAD: load_ready=1. load_valid writes load_byte to mem[wr_ptr], wr_ptr++, load_count++.
- LOAD --(load_valid & load_last) or (load_valid & wr_ptr==DEPTH-1)--> RUN, load_done=1 next cycle. Bytes after a full memory are never accepted.
- load_start in LOAD restarts the load: pointer/count cleared, any same-cycle load byte discarded. load_start has priority over load_valid in every state.
- load_valid outside LOAD is ignored.
- Fetch: every fetch_req cycle yields fetch_valid=1 exactly one cycle later, in any state.
- Byte addresses computed as (pc+k) mod DEPTH, k=0..INSTR_BYTES-1 (wrap-around).
- fetch_fault=1 if any of: state != RUN; load_count < DEPTH and pc+INSTR_BYTES > load_count (unwrapped ADDR_W+1-bit sum); ALIGN_CHECK=1 and pc mod INSTR_BYTES != 0. On fault instruction=0.
- load_count == DEPTH: no range fault; wrapped fetch legal.
- instruction and fetch_fault hold their last values while fetch_valid=0.

## Timing
- Fetch latency 1 cycle; one request per cycle, fully pipelined, no back-pressure.
- Load throughput 1 byte/cycle; write visible to a fetch issued the cycle after the write edge.
- fetch_req in the same cycle as load_start (from RUN): served against pre-edge state, i.e. not faulted for state, old contents.
- fetch_req on the cycle LOAD->RUN edge occurs: sampled state is LOAD, so faults.
- rst mid-load: IDLE, load_count=0, in-flight fetch result discarded (fetch_valid=0 next cycle); stale bytes unreachable until reloaded.
- load_done is high exactly one cycle, the cycle after the final byte edge.

## Test plan
- Load 8 bytes 00..07 (last on byte 07) -> load_done one pulse, load_count=8; fetch pc=0 -> next cycle instruction=32'h03020100, fault=0; pc=4 -> 32'h07060504.
- Same image, fetch pc=5 -> fetch_fault=1, instruction=0; with ALIGN_CHECK=1 fetch pc=2 -> fault, with ALIGN_CHECK=0 -> 32'h05040302.
- Fill all 256 bytes with value=address, no load_last -> auto RUN at wr_ptr=255, load_count=256; fetch pc=254 -> 32'h0100FFFE, no fault.
- Fetch before any load and during LOAD -> fetch_valid=1, fetch_fault=1; back-to-back fetch_req on pc 0,4,0 in RUN -> three consecutive valid results in order.
- load_start asserted mid-load together with load_valid -> byte dropped, load_count=0, subsequent bytes written from address 0.
- rst asserted after 3 loaded bytes and with a fetch in flight -> next cycle all outputs at reset values, state IDLE; fetch pc=0 faults.

Source files
------------

// File: rtl/instruction_memory_ld_fp_if.sv
// Load/fetch bus for the FP CPU instruction memory.
// The master streams program bytes in and issues fetches; the slave is the memory.
interface instruction_memory_ld_fp_if #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned INSTR_BYTES = 4
);
  logic                       load_start;
  logic                       load_valid;
  logic [7:0]                 load_byte;
  logic                       load_last;
  logic                       load_ready;
  logic                       load_done;
  logic [ADDR_W:0]            load_count;
  logic                       fetch_req;
  logic [ADDR_W-1:0]          pc;
  logic                       fetch_valid;
  logic                       fetch_fault;
  logic [8*INSTR_BYTES-1:0]   instruction;

  modport master (
    output load_start, load_valid, load_byte, load_last, fetch_req, pc,
    input  load_ready, load_done, load_count, fetch_valid, fetch_fault, instruction
  );

  modport slave (
    input  load_start, load_valid, load_byte, load_last, fetch_req, pc,
    output load_ready, load_done, load_count, fetch_valid, fetch_fault, instruction
  );
endinterface

// File: rtl/instruction_memory_ld_fp.sv
// Byte-addressed instruction memory with a serial program-load port and a
// registered, fault-checked little-endian fetch port (one-cycle latency).
module instruction_memory_ld_fp #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned INSTR_BYTES = 4,
  parameter int unsigned ALIGN_CHECK = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  instruction_memory_ld_fp_if.slave   bus
);
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned INSTR_W = 8 * INSTR_BYTES;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t               state_q, state_n;
  logic [ADDR_W-1:0]    wr_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic [7:0]           mem [DEPTH];

  logic                 load_we_c, load_end_c, load_ready_n, load_done_n;
  logic                 load_ready_q, load_done_q;
  logic                 fetch_valid_q, fetch_fault_q;
  logic [INSTR_W-1:0]   instr_q;
  logic                 fetch_fault_c;
  logic [INSTR_W-1:0]   fetch_data_c;
  logic [CNT_W-1:0]     fetch_end_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Next state: load_start wins over everything, including a final byte
  always_comb begin
    state_n = state_q;
    if (bus.load_start)  state_n = LOAD;
    else if (load_end_c) state_n = RUN;
  end

  // FSM outputs: byte acceptance, end of image, next registered flags
  always_comb begin
    load_we_c    = (state_q == LOAD) && bus.load_valid && !bus.load_start;
    load_end_c   = load_we_c && (bus.load_last || (wr_ptr_q == ADDR_W'(DEPTH - 1)));
    load_ready_n = (state_n == LOAD);
    load_done_n  = load_end_c;
  end

  // Fetch gather with address wrap, and fault qualification on pre-edge state
  always_comb begin
    fetch_data_c = '0;
    for (int unsigned k = 0; k < INSTR_BYTES; k++) begin
      fetch_data_c[8*k +: 8] = mem[bus.pc + ADDR_W'(k)];
    end
    fetch_end_c   = CNT_W'(bus.pc) + CNT_W'(INSTR_BYTES);
    fetch_fault_c = (state_q != RUN)
                 || ((count_q < CNT_W'(DEPTH)) && (fetch_end_c > count_q))
                 || ((ALIGN_CHECK != 0) && ((32'(bus.pc) % INSTR_BYTES) != 0));
  end

  // Byte array is intentionally not reset; stale bytes are fenced by count_q
  always_ff @(posedge clk) begin
    if (!rst && load_we_c) mem[wr_ptr_q] <= bus.load_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      count_q       <= '0;
      load_ready_q  <= 1'b0;
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
      instr_q       <= '0;
    end else begin
      load_ready_q  <= load_ready_n;
      load_done_q   <= load_done_n;
      fetch_valid_q <= bus.fetch_req;
      if (bus.load_start) begin
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else if (load_we_c) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        count_q  <= count_q + CNT_W'(1);
      end
      if (bus.fetch_req) begin
        fetch_fault_q <= fetch_fault_c;
        instr_q       <= fetch_fault_c ? '0 : fetch_data_c;
      end
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.load_done   = load_done_q;
  assign bus.load_count  = count_q;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.fetch_fault = fetch_fault_q;
  assign bus.instruction = instr_q;
endmodule

// File: tb/tb_instruction_memory_ld_fp.sv
// Bench for instruction_memory_ld_fp: two instances (alignment check off/on)
// share stimulus; fetch results are scoreboarded, load behaviour checked inline.
module tb_instruction_memory_ld_fp;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned IB     = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_memory_ld_fp_if #(.ADDR_W(ADDR_W), .INSTR_BYTES(IB)) bus0 ();
  instruction_memory_ld_fp_if #(.ADDR_W(ADDR_W), .INSTR_BYTES(IB)) bus1 ();

  assign bus1.load_start = bus0.load_start;
  assign bus1.load_valid = bus0.load_valid;
  assign bus1.load_byte  = bus0.load_byte;
  assign bus1.load_last  = bus0.load_last;
  assign bus1.fetch_req  = bus0.fetch_req;
  assign bus1.pc         = bus0.pc;

  instruction_memory_ld_fp #(.ADDR_W(ADDR_W), .INSTR_BYTES(IB), .ALIGN_CHECK(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  instruction_memory_ld_fp #(.ADDR_W(ADDR_W), .INSTR_BYTES(IB), .ALIGN_CHECK(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int          cyc;
    int          pc;
    logic        f0;
    logic [31:0] i0;
    logic        f1;
    logic [31:0] i1;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc     = 0;
  int   n_pass  = 0;
  int   n_total = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Scoreboard monitor: results due this cycle are popped and compared
  always @(posedge clk) begin
    #1;
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      n_total++;
      if (bus0.fetch_valid !== 1'b1 || bus1.fetch_valid !== 1'b1)
        $display("FAIL fetch_valid pc=%0d got %b/%b want 1/1", mon_e.pc, bus0.fetch_valid, bus1.fetch_valid);
      else n_pass++;
      n_total++;
      if (bus0.fetch_fault !== mon_e.f0)
        $display("FAIL fault_a0 pc=%0d got %b want %b", mon_e.pc, bus0.fetch_fault, mon_e.f0);
      else n_pass++;
      n_total++;
      if (bus0.instruction !== mon_e.i0)
        $display("FAIL instr_a0 pc=%0d got %h want %h", mon_e.pc, bus0.instruction, mon_e.i0);
      else n_pass++;
      n_total++;
      if (bus1.fetch_fault !== mon_e.f1)
        $display("FAIL fault_a1 pc=%0d got %b want %b", mon_e.pc, bus1.fetch_fault, mon_e.f1);
      else n_pass++;
      n_total++;
      if (bus1.instruction !== mon_e.i1)
        $display("FAIL instr_a1 pc=%0d got %h want %h", mon_e.pc, bus1.instruction, mon_e.i1);
      else n_pass++;
    end else if (bus0.fetch_valid !== 1'b0 || bus1.fetch_valid !== 1'b0) begin
      n_total++;
      $display("FAIL stray_fetch_valid cyc=%0d got %b/%b want 0/0", cyc, bus0.fetch_valid, bus1.fetch_valid);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
    bus0.fetch_req  = 1'b0;
    bus0.load_start = 1'b0;
    bus0.load_valid = 1'b0;
    bus0.load_last  = 1'b0;
  endtask

  task automatic issue_fetch(input int pc, input logic f0, input logic [31:0] i0,
                             input logic f1, input logic [31:0] i1);
    bus0.fetch_req = 1'b1;
    bus0.pc        = ADDR_W'(pc);
    sb.push_back('{cyc + 1, pc, f0, i0, f1, i1});
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_total++; if (bus0.load_ready !== 1'b0) $display("FAIL rst_load_ready got %b want 0", bus0.load_ready); else n_pass++;
    n_total++; if (bus0.load_done !== 1'b0) $display("FAIL rst_load_done got %b want 0", bus0.load_done); else n_pass++;
    n_total++; if (bus0.load_count !== 9'd0) $display("FAIL rst_load_count got %0d want 0", bus0.load_count); else n_pass++;
    n_total++; if (bus0.fetch_valid !== 1'b0) $display("FAIL rst_fetch_valid got %b want 0", bus0.fetch_valid); else n_pass++;
    n_total++; if (bus0.fetch_fault !== 1'b0) $display("FAIL rst_fetch_fault got %b want 0", bus0.fetch_fault); else n_pass++;
    n_total++; if (bus0.instruction !== 32'h0) $display("FAIL rst_instruction got %h want 0", bus0.instruction); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fetch_before_load();
    issue_fetch(0, 1'b1, 32'h0, 1'b1, 32'h0);
    tick();
    tick();
  endtask

  task automatic test_load_small();
    bus0.load_start = 1'b1;
    tick();
    n_total++; if (bus0.load_ready !== 1'b1) $display("FAIL load_ready_in_load got %b want 1", bus0.load_ready); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      bus0.load_valid = 1'b1;
      bus0.load_byte  = 8'(i);
      bus0.load_last  = (i == 7);
      if (i == 3 || i == 7) issue_fetch(0, 1'b1, 32'h0, 1'b1, 32'h0);
      tick();
      if (i == 6) begin
        n_total++; if (bus0.load_done !== 1'b0) $display("FAIL load_done_early got %b want 0", bus0.load_done); else n_pass++;
      end
    end
    n_total++; if (bus0.load_done !== 1'b1) $display("FAIL load_done_pulse got %b want 1", bus0.load_done); else n_pass++;
    n_total++; if (bus0.load_count !== 9'd8) $display("FAIL load_count_small got %0d want 8", bus0.load_count); else n_pass++;
    n_total++; if (bus0.load_ready !== 1'b0) $display("FAIL load_ready_run got %b want 0", bus0.load_ready); else n_pass++;
    tick();
    n_total++; if (bus0.load_done !== 1'b0) $display("FAIL load_done_width got %b want 0", bus0.load_done); else n_pass++;
  endtask

  task automatic test_fetch_run();
    issue_fetch(0, 1'b0, 32'h03020100, 1'b0, 32'h03020100);
    tick();
    issue_fetch(4, 1'b0, 32'h07060504, 1'b0, 32'h07060504);
    tick();
    tick();
    n_total++; if (bus0.instruction !== 32'h07060504) $display("FAIL hold_instruction got %h want 07060504", bus0.instruction); else n_pass++;
    n_total++; if (bus0.fetch_fault !== 1'b0) $display("FAIL hold_fault got %b want 0", bus0.fetch_fault); else n_pass++;
    issue_fetch(5, 1'b1, 32'h0, 1'b1, 32'h0);
    tick();
    issue_fetch(2, 1'b0, 32'h05040302, 1'b1, 32'h0);
    tick();
    issue_fetch(0, 1'b0, 32'h03020100, 1'b0, 32'h03020100);
    tick();
    issue_fetch(4, 1'b0, 32'h07060504, 1'b0, 32'h07060504);
    tick();
    issue_fetch(0, 1'b0, 32'h03020100, 1'b0, 32'h03020100);
    tick();
    tick();
  endtask

  task automatic test_restart();
    bus0.load_start = 1'b1;
    issue_fetch(0, 1'b0, 32'h03020100, 1'b0, 32'h03020100);
    tick();
    n_total++; if (bus0.load_count !== 9'd0) $display("FAIL restart_count got %0d want 0", bus0.load_count); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      bus0.load_valid = 1'b1;
      bus0.load_byte  = 8'(8'hA0 + i);
      tick();
    end
    n_total++; if (bus0.load_count !== 9'd2) $display("FAIL partial_count got %0d want 2", bus0.load_count); else n_pass++;
    bus0.load_start = 1'b1;
    bus0.load_valid = 1'b1;
    bus0.load_byte  = 8'hEE;
    tick();
    n_total++; if (bus0.load_count !== 9'd0) $display("FAIL dropped_byte_count got %0d want 0", bus0.load_count); else n_pass++;
    n_total++; if (bus0.load_ready !== 1'b1) $display("FAIL restart_ready got %b want 1", bus0.load_ready); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      bus0.load_valid = 1'b1;
      bus0.load_byte  = 8'(8'hB0 + i);
      bus0.load_last  = (i == 3);
      tick();
    end
    n_total++; if (bus0.load_count !== 9'd4) $display("FAIL reload_count got %0d want 4", bus0.load_count); else n_pass++;
    issue_fetch(0, 1'b0, 32'hB3B2B1B0, 1'b0, 32'hB3B2B1B0);
    tick();
    issue_fetch(1, 1'b1, 32'h0, 1'b1, 32'h0);
    tick();
    tick();
  endtask

  task automatic test_full();
    bus0.load_start = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      bus0.load_valid = 1'b1;
      bus0.load_byte  = 8'(i);
      tick();
      if (i == 254) begin
        n_total++; if (bus0.load_ready !== 1'b1) $display("FAIL full_ready_at_254 got %b want 1", bus0.load_ready); else n_pass++;
      end
    end
    n_total++; if (bus0.load_done !== 1'b1) $display("FAIL full_done got %b want 1", bus0.load_done); else n_pass++;
    n_total++; if (bus0.load_count !== 9'd256) $display("FAIL full_count got %0d want 256", bus0.load_count); else n_pass++;
    n_total++; if (bus0.load_ready !== 1'b0) $display("FAIL full_ready got %b want 0", bus0.load_ready); else n_pass++;
    bus0.load_valid = 1'b1;
    bus0.load_byte  = 8'h77;
    tick();
    n_total++; if (bus0.load_count !== 9'd256) $display("FAIL overfill_count got %0d want 256", bus0.load_count); else n_pass++;
    issue_fetch(254, 1'b0, 32'h0100FFFE, 1'b1, 32'h0);
    tick();
    issue_fetch(255, 1'b0, 32'h020100FF, 1'b1, 32'h0);
    tick();
    issue_fetch(252, 1'b0, 32'hFFFEFDFC, 1'b0, 32'hFFFEFDFC);
    tick();
    issue_fetch(0, 1'b0, 32'h03020100, 1'b0, 32'h03020100);
    tick();
    tick();
  endtask

  task automatic test_reset_midload();
    bus0.load_start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus0.load_valid = 1'b1;
      bus0.load_byte  = 8'(8'h11 * (i + 1));
      tick();
    end
    n_total++; if (bus0.load_count !== 9'd3) $display("FAIL midload_count got %0d want 3", bus0.load_count); else n_pass++;
    rst            = 1'b1;
    bus0.fetch_req = 1'b1;
    bus0.pc        = '0;
    tick();
    n_total++; if (bus0.fetch_valid !== 1'b0) $display("FAIL rst_inflight_valid got %b want 0", bus0.fetch_valid); else n_pass++;
    n_total++; if (bus0.load_ready !== 1'b0) $display("FAIL rst_mid_ready got %b want 0", bus0.load_ready); else n_pass++;
    n_total++; if (bus0.load_count !== 9'd0) $display("FAIL rst_mid_count got %0d want 0", bus0.load_count); else n_pass++;
    n_total++; if (bus0.instruction !== 32'h0) $display("FAIL rst_mid_instr got %h want 0", bus0.instruction); else n_pass++;
    rst             = 1'b0;
    bus0.load_valid = 1'b1;
    bus0.load_byte  = 8'h55;
    tick();
    n_total++; if (bus0.load_count !== 9'd0) $display("FAIL idle_ignores_byte got %0d want 0", bus0.load_count); else n_pass++;
    issue_fetch(0, 1'b1, 32'h0, 1'b1, 32'h0);
    tick();
    tick();
  endtask

  initial begin
    rst             = 1'b1;
    bus0.load_start = 1'b0;
    bus0.load_valid = 1'b0;
    bus0.load_byte  = '0;
    bus0.load_last  = 1'b0;
    bus0.fetch_req  = 1'b0;
    bus0.pc         = '0;
    test_reset();
    test_fetch_before_load();
    test_load_small();
    test_fetch_run();
    test_restart();
    test_full();
    test_reset_midload();
    n_total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain got %0d want 0 pending", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
